iter_muldiv_unit: RTL and testbench

//  Multi-cycle RV32M multiply/divide unit replacing the single-cycle '*' and '/' ALU paths.

---
 rtl/iter_muldiv_unit_if.sv | 24 ++
 rtl/iter_muldiv_unit.sv | 184 ++++++++++++++++++
 tb/tb_iter_muldiv_unit.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/iter_muldiv_unit_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The master is the issuing control unit; the slave is the unit itself.
interface iter_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/iter_muldiv_unit.sv
// Multi-cycle RV32M multiply/divide: radix-2 shift-add multiply and restoring divide, one bit per clock.
// Define MULDIV_EARLY_OUT_EN to let trivial operand cases bypass the iteration and complete on the accept edge.
module iter_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  iter_muldiv_unit_if.slave   bus
);

  localparam int CNTW = $clog2(WIDTH + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             a_neg_q, a_neg_d;
  logic             b_neg_q, b_neg_d;
  logic             dz_q, dz_d;

  logic             a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] it_hi, it_lo;

  function automatic logic [WIDTH-1:0] cond_neg(input logic n, input logic [WIDTH-1:0] v);
    return n ? (~v + WIDTH'(1)) : v;
  endfunction

  // Sign correction of the unsigned core's product / quotient / remainder.
  function automatic logic [WIDTH-1:0] finalize(input logic [2:0] op, input logic an, input logic bn,
                                                input logic dz, input logic [WIDTH-1:0] hi,
                                                input logic [WIDTH-1:0] lo);
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   r;
    prod = {hi, lo};
    if (an ^ bn) prod = ~prod + (2*WIDTH)'(1);
    case (op)
      OP_MUL:                       r = prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: r = prod[2*WIDTH-1:WIDTH];
      OP_DIV:                       r = dz ? '1 : cond_neg(an ^ bn, lo);
      OP_DIVU:                      r = lo;
      OP_REM:                       r = cond_neg(an, hi);
      default:                      r = hi;
    endcase
    return r;
  endfunction

`ifdef MULDIV_EARLY_OUT_EN
  function automatic logic early_hit(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
    if (!op[2]) return (a == '0) || (b == '0);
    return (b == '0) || (b == WIDTH'(1)) || (!op[0] && (b == '1));
  endfunction

  // b==-1 on DIV also covers the MIN_INT overflow case: negating MIN_INT yields MIN_INT.
  function automatic logic [WIDTH-1:0] early_res(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    if (!op[2])               r = '0;
    else if (b == '0)         r = op[1] ? a : '1;
    else if (op[1])           r = '0;
    else if (b == WIDTH'(1))  r = a;
    else                      r = ~a + WIDTH'(1);
    return r;
  endfunction
`endif

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;

  always_comb begin
    a_signed = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) || (bus.op == OP_DIV) || (bus.op == OP_REM);
    b_signed = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
    a_neg    = a_signed & bus.a[WIDTH-1];
    b_neg    = b_signed & bus.b[WIDTH-1];
    mag_a    = cond_neg(a_neg, bus.a);
    mag_b    = cond_neg(b_neg, bus.b);
  end

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    if (op_q[2]) begin
      it_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      it_lo = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      it_hi = mul_sum[WIDTH:1];
      it_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    dz_d     = dz_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = CALC;
          cnt_d   = CNT_LAST;
          op_d    = bus.op;
          a_neg_d = a_neg;
          b_neg_d = b_neg;
          dz_d    = (bus.b == '0);
          hi_d    = '0;
          lo_d    = bus.op[2] ? mag_a : mag_b;
          opnd_d  = bus.op[2] ? mag_b : mag_a;
`ifdef MULDIV_EARLY_OUT_EN
          if (early_hit(bus.op, bus.a, bus.b)) begin
            state_d  = DONE;
            result_d = early_res(bus.op, bus.a, bus.b);
          end
`endif
        end
      end
      CALC: begin
        hi_d = it_hi;
        lo_d = it_lo;
        if (cnt_q == '0) begin
          state_d  = DONE;
          result_d = finalize(op_q, a_neg_q, b_neg_q, dz_q, it_hi, it_lo);
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Datapath registers are only meaningful after an accept, so they carry no reset.
  always_ff @(posedge clk) begin
    op_q    <= op_d;
    hi_q    <= hi_d;
    lo_q    <= lo_d;
    opnd_q  <= opnd_d;
    a_neg_q <= a_neg_d;
    b_neg_q <= b_neg_d;
    dz_q    <= dz_d;
  end

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Directed testbench for iter_muldiv_unit at WIDTH=32; honours MULDIV_EARLY_OUT_EN for latency expectations.
module tb_iter_muldiv_unit;

  localparam int W = 32;
  localparam int FULL_LAT = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 0;   // out_valid already high right after the accepting edge
`else
  localparam int SPECIAL_LAT = 32;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  iter_muldiv_unit_if #(.WIDTH(W)) bus();

  iter_muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Issue one op (in_ready assumed high), then count edges after the accept until out_valid.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output int lat, output logic rdy_low);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op       = 3'b111;
    bus.a        = 32'hDEAD_BEEF;
    bus.b        = 32'h0000_0003;
    lat     = 0;
    rdy_low = 1'b1;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready) rdy_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result;
  endtask

  task automatic retire();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({bus.in_ready, bus.out_valid, bus.result} !== {1'b1, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_state: got rdy=%b vld=%b res=%h, expected rdy=1 vld=0 res=0",
               bus.in_ready, bus.out_valid, bus.result);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul_latency();
    logic [W-1:0] res; int lat; logic rl;
    do_op(3'b000, 32'd7, 32'd6, res, lat, rl);
    vectors++;
    if (res !== 32'h0000_002A) begin
      miscompares++; $display("FAIL mul_7x6: got %h, expected 0000002a", res);
    end
    vectors++;
    if (lat !== FULL_LAT) begin
      miscompares++; $display("FAIL mul_latency: got %0d, expected %0d", lat, FULL_LAT);
    end
    vectors++;
    if (rl !== 1'b1) begin
      miscompares++; $display("FAIL mul_in_ready_low: got %b, expected 1", rl);
    end
    retire();
  endtask

  task automatic test_arith();
    logic [2:0]   ops [10] = '{3'b001, 3'b011, 3'b010, 3'b000, 3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110};
    logic [W-1:0] as  [10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9,
                               32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7, 32'd7};
    logic [W-1:0] bs  [10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd5, 32'd2,
                               32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    logic [W-1:0] exp [10] = '{32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'hFFFF_FFFD,
                               32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFD, 32'd1};
    logic [W-1:0] res; int lat; logic rl;
    for (int i = 0; i < 10; i++) begin
      do_op(ops[i], as[i], bs[i], res, lat, rl);
      vectors++;
      if (res !== exp[i] || lat !== FULL_LAT) begin
        miscompares++;
        $display("FAIL arith[%0d] op=%b: got %h lat %0d, expected %h lat %0d",
                 i, ops[i], res, lat, exp[i], FULL_LAT);
      end
      retire();
    end
  endtask

  task automatic test_special();
    logic [2:0]   ops [8] = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110, 3'b000, 3'b100};
    logic [W-1:0] as  [8] = '{32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h1234, 32'd5};
    logic [W-1:0] bs  [8] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF};
    logic [W-1:0] exp [8] = '{32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'h0,
                              32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFFB};
    logic [W-1:0] res; int lat; logic rl;
    for (int i = 0; i < 8; i++) begin
      do_op(ops[i], as[i], bs[i], res, lat, rl);
      vectors++;
      if (res !== exp[i] || lat !== SPECIAL_LAT) begin
        miscompares++;
        $display("FAIL special[%0d] op=%b: got %h lat %0d, expected %h lat %0d",
                 i, ops[i], res, lat, exp[i], SPECIAL_LAT);
      end
      retire();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] res; int lat; logic rl; int unstable;
    bus.out_ready = 1'b0;
    do_op(3'b000, 32'd7, 32'd6, res, lat, rl);
    unstable = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if ({bus.out_valid, bus.in_ready, bus.result} !== {1'b1, 1'b0, 32'h2A}) unstable++;
    end
    vectors++;
    if (unstable !== 0) begin
      miscompares++; $display("FAIL hold_done: got %0d unstable cycles, expected 0", unstable);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL retire: got rdy=%b vld=%b, expected rdy=1 vld=0", bus.in_ready, bus.out_valid);
    end
    do_op(3'b101, 32'd100, 32'd7, res, lat, rl);
    vectors++;
    if (res !== 32'd14 || lat !== FULL_LAT) begin
      miscompares++; $display("FAIL back_to_back: got %h lat %0d, expected 0000000e lat %0d", res, lat, FULL_LAT);
    end
    retire();
  endtask

  task automatic test_reset_mid_calc();
    logic [W-1:0] res; int lat; logic rl; int spurious;
    bus.in_valid = 1'b1;
    bus.op       = 3'b000;
    bus.a        = 32'h1234_5678;
    bus.b        = 32'd9;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    vectors++;
    if ({bus.out_valid, bus.in_ready, bus.result} !== {1'b0, 1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_mid_calc: got vld=%b rdy=%b res=%h, expected vld=0 rdy=1 res=0",
               bus.out_valid, bus.in_ready, bus.result);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) spurious++;
    end
    vectors++;
    if (spurious !== 0) begin
      miscompares++; $display("FAIL aborted_op_result: got %0d valid cycles, expected 0", spurious);
    end
    do_op(3'b000, 32'd3, 32'd5, res, lat, rl);
    vectors++;
    if (res !== 32'd15 || lat !== FULL_LAT) begin
      miscompares++; $display("FAIL mul_after_reset: got %h lat %0d, expected 0000000f lat %0d", res, lat, FULL_LAT);
    end
    retire();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.op        = 3'b000;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_mul_latency();
    test_arith();
    test_special();
    test_back_to_back();
    test_reset_mid_calc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
